// File: rtl/mk_test4a_reader.sv
// Calls target method4 once per request, then streams its 3x4 element result one
// element per handshake (forward or reversed order), counting completed transactions.
module mk_test4a_reader #(
  parameter int REVERSE = 0
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [31:0]  req_arg,
  input  logic         RDY_method4,
  output logic         EN_method4,
  output logic [31:0]  method4_in1,
  input  logic [215:0] method4,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [1:0]   out_row,
  output logic [1:0]   out_col,
  output logic [2:0]   out_a,
  output logic [3:0]   out_b,
  output logic [2:0]   out_c_x,
  output logic [3:0]   out_c_y,
  output logic [3:0]   out_c_z,
  output logic         out_last,
  output logic [7:0]   txn_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALL  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic [3:0] IDX_FIRST = (REVERSE != 0) ? 4'd11 : 4'd0;
  localparam logic [3:0] IDX_LAST  = (REVERSE != 0) ? 4'd0  : 4'd11;

  state_t         state_q, state_d;
  logic [31:0]    arg_q, arg_d;
  logic [215:0]   buf_q, buf_d;
  logic [3:0]     idx_q, idx_d;
  logic [7:0]     txn_q, txn_d;
  logic [17:0]    elem;
  logic           is_last;

  // Element k occupies the k-th 18-bit slot counting down from the MSB.
  function automatic logic [17:0] elem_at(input logic [215:0] v, input logic [3:0] k);
    logic [17:0] e;
    e = '0;
    for (int i = 0; i < 12; i++) begin
      if (k == 4'(i)) e = v[215 - 18*i -: 18];
    end
    return e;
  endfunction

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      arg_q   <= '0;
      buf_q   <= '0;
      idx_q   <= '0;
      txn_q   <= '0;
    end else begin
      state_q <= state_d;
      arg_q   <= arg_d;
      buf_q   <= buf_d;
      idx_q   <= idx_d;
      txn_q   <= txn_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    arg_d      = arg_q;
    buf_d      = buf_q;
    idx_d      = idx_q;
    txn_d      = txn_q;
    req_ready  = 1'b0;
    EN_method4 = 1'b0;
    out_valid  = 1'b0;
    is_last    = 1'b0;
    elem       = '0;
    out_row    = '0;
    out_col    = '0;
    unique case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          arg_d   = req_arg;
          state_d = S_CALL;
        end
      end
      S_CALL: begin
        EN_method4 = RDY_method4;
        if (RDY_method4) begin
          buf_d   = method4;
          idx_d   = IDX_FIRST;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        out_valid = 1'b1;
        is_last   = (idx_q == IDX_LAST);
        elem      = elem_at(buf_q, idx_q);
        out_row   = idx_q[3:2];
        out_col   = idx_q[1:0];
        if (out_ready) begin
          if (is_last) begin
            state_d = S_IDLE;
            txn_d   = txn_q + 8'd1;
          end else if (REVERSE != 0) begin
            idx_d = idx_q - 4'd1;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign method4_in1 = arg_q;
  assign out_last    = is_last;
  assign out_a       = elem[17:15];
  assign out_b       = elem[14:11];
  assign out_c_x     = elem[10:8];
  assign out_c_y     = elem[7:4];
  assign out_c_z     = elem[3:0];
  assign txn_count   = txn_q;

endmodule

// File: tb/tb_mk_test4a_reader.sv
// Directed bench: forward and reversed instances share stimulus; each output is
// compared against a per-element table built by the bench.
module tb_mk_test4a_reader;

  logic         CLK = 1'b0;
  logic         RST_N;
  logic         req_valid;
  logic [31:0]  req_arg;
  logic         RDY_method4;
  logic [215:0] method4;
  logic         out_ready;

  logic         f_rr, f_en, f_ov, f_last;
  logic [31:0]  f_in1;
  logic [1:0]   f_row, f_col;
  logic [2:0]   f_a, f_cx;
  logic [3:0]   f_b, f_cy, f_cz;
  logic [7:0]   f_txn;

  logic         r_rr, r_en, r_ov, r_last;
  logic [31:0]  r_in1;
  logic [1:0]   r_row, r_col;
  logic [2:0]   r_a, r_cx;
  logic [3:0]   r_b, r_cy, r_cz;
  logic [7:0]   r_txn;

  logic [17:0]  ex [12];
  int           n_pass = 0;
  int           n_chk  = 0;

  always #5 CLK = ~CLK;

  mk_test4a_reader #(.REVERSE(0)) dut_f (
    .CLK(CLK), .RST_N(RST_N), .req_valid(req_valid), .req_ready(f_rr), .req_arg(req_arg),
    .RDY_method4(RDY_method4), .EN_method4(f_en), .method4_in1(f_in1), .method4(method4),
    .out_valid(f_ov), .out_ready(out_ready), .out_row(f_row), .out_col(f_col),
    .out_a(f_a), .out_b(f_b), .out_c_x(f_cx), .out_c_y(f_cy), .out_c_z(f_cz),
    .out_last(f_last), .txn_count(f_txn)
  );

  mk_test4a_reader #(.REVERSE(1)) dut_r (
    .CLK(CLK), .RST_N(RST_N), .req_valid(req_valid), .req_ready(r_rr), .req_arg(req_arg),
    .RDY_method4(RDY_method4), .EN_method4(r_en), .method4_in1(r_in1), .method4(method4),
    .out_valid(r_ov), .out_ready(out_ready), .out_row(r_row), .out_col(r_col),
    .out_a(r_a), .out_b(r_b), .out_c_x(r_cx), .out_c_y(r_cy), .out_c_z(r_cz),
    .out_last(r_last), .txn_count(r_txn)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic load_m4();
    for (int k = 0; k < 12; k++) method4[215 - 18*k -: 18] = ex[k];
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_ctl"}, 64'({f_en, r_en, f_ov, r_ov, f_last, r_last}), 64'd0);
    chk({tag, "_fld"}, 64'({f_row, f_col, f_a, f_b, f_cx, f_cy, f_cz,
                            r_row, r_col, r_a, r_b, r_cx, r_cy, r_cz}), 64'd0);
  endtask

  // One request; rdy_delay stall cycles in CALL; bp=1 gives out_ready 1,0,0,1,0,0...;
  // stops after abort_at handshakes when abort_at < 12.
  task automatic run_txn(input logic [31:0] arg, input int rdy_delay, input int bp,
                         input int abort_at, input logic [7:0] exp_txn);
    int k;
    int rk;
    int cyc;
    req_valid   = 1'b1;
    req_arg     = arg;
    RDY_method4 = 1'b0;
    out_ready   = 1'b1;
    #1;
    chk("idle_req_ready", 64'({f_rr, r_rr}), 64'b11);
    chk_quiet("idle");
    tick();
    req_arg = ~arg;
    for (int d = 0; d < rdy_delay; d++) begin
      RDY_method4 = 1'b0;
      #1;
      chk("stall_ready", 64'({f_rr, r_rr}), 64'd0);
      chk_quiet("stall");
      tick();
    end
    RDY_method4 = 1'b1;
    #1;
    chk("call_en", 64'({f_en, r_en}), 64'b11);
    chk("call_in1", 64'({f_in1, r_in1}), {arg, arg});
    chk("call_ready", 64'({f_rr, r_rr}), 64'd0);
    tick();
    k   = 0;
    cyc = 0;
    while (k < abort_at && k < 12 && cyc < 200) begin
      out_ready = (bp == 0) ? 1'b1 : ((cyc % 3) == 0);
      #1;
      rk = 11 - k;
      chk("drain_ctl", 64'({f_en, r_en, f_rr, r_rr, f_ov, r_ov}), 64'b000011);
      chk("drain_in1", 64'(f_in1), 64'(arg));
      chk("fwd_elem", 64'({f_row, f_col, f_a, f_b, f_cx, f_cy, f_cz, f_last}),
          64'({k[3:2], k[1:0], ex[k], (k == 11)}));
      chk("rev_elem", 64'({r_row, r_col, r_a, r_b, r_cx, r_cy, r_cz, r_last}),
          64'({rk[3:2], rk[1:0], ex[rk], (rk == 0)}));
      if (out_ready) k++;
      tick();
      cyc++;
    end
    if (cyc >= 200) chk("drain_timeout", 64'(k), 64'd12);
    if (abort_at < 12) return;
    req_valid   = 1'b0;
    RDY_method4 = 1'b0;
    out_ready   = 1'b0;
    #1;
    chk("done_ready", 64'({f_rr, r_rr}), 64'b11);
    chk_quiet("done");
    chk("done_txn", 64'({f_txn, r_txn}), 64'({exp_txn, exp_txn}));
  endtask

  initial begin
    RST_N       = 1'b0;
    req_valid   = 1'b0;
    req_arg     = '0;
    RDY_method4 = 1'b1;
    method4     = '1;
    out_ready   = 1'b1;
    for (int k = 0; k < 12; k++) ex[k] = '0;
    repeat (2) tick();
    chk("rst_ready", 64'({f_rr, r_rr}), 64'b11);
    chk_quiet("rst");
    chk("rst_txn", 64'({f_txn, r_txn}), 64'd0);
    chk("rst_in1", 64'({f_in1, r_in1}), 64'd0);
    RST_N = 1'b1;
    tick();

    // Basic: distinct value in every field of every element.
    for (int k = 0; k < 12; k++)
      ex[k] = {3'(k), 4'(15 - k), 3'(k + 1), 4'(k + 3), 4'(k ^ 5)};
    load_m4();
    run_txn(32'h0000_00A5, 0, 0, 12, 8'd1);

    // Field map: element 0 = a=5,b=6,c_x=3,c_y=9,c_z=14 -> 101_0110_011_1001_1110.
    for (int k = 0; k < 12; k++) ex[k] = '0;
    ex[0] = 18'h2B39E;
    load_m4();
    run_txn(32'h0BAD_F00D, 0, 0, 12, 8'd2);

    // Target stall for 7 cycles.
    for (int k = 0; k < 12; k++) ex[k] = 18'($urandom);
    load_m4();
    run_txn(32'h1234_5678, 7, 0, 12, 8'd3);

    // Downstream backpressure; method4 changes mid-drain must not leak through.
    for (int k = 0; k < 12; k++) ex[k] = 18'($urandom);
    load_m4();
    fork
      begin
        repeat (4) @(posedge CLK);
        #2;
        method4 = ~method4;
      end
    join_none
    run_txn(32'hFFFF_FFFF, 2, 1, 12, 8'd4);

    // Reset in the middle of the drain after 5 elements.
    for (int k = 0; k < 12; k++) ex[k] = 18'($urandom);
    load_m4();
    run_txn(32'h0000_0042, 0, 0, 5, 8'd0);
    req_valid = 1'b0;
    RST_N     = 1'b0;
    #1;
    chk("mid_rst_ready", 64'({f_rr, r_rr}), 64'b11);
    chk_quiet("mid_rst");
    chk("mid_rst_txn", 64'({f_txn, r_txn}), 64'd0);
    tick();
    tick();
    RST_N = 1'b1;
    tick();
    run_txn(32'h0000_0077, 1, 0, 12, 8'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
